pc_fetch_ctrl: RTL and testbench

// - Fetch-side partner of branch resolution. Owns the PC and predicts every branch not-taken.
// - Queues the target of each issued branch in order.
// - Consumes the registered taken/not-taken result from branch resolution.
// - On taken: redirects the PC to the queued target and flushes the wrong-path pipeline.
// - Sits between decode, instruction memory and the branch-resolution stage.

---
 rtl/cpu_pkg.sv | 20 ++
 rtl/branch_tgt_fifo.sv | 63 ++++++
 rtl/pc_fetch_ctrl.sv | 126 ++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch side.
// Covers branch opcodes, the branch decode helper and the fetch FSM state type.
package cpu_pkg;

   localparam logic [4:0] OP_BEQ = 5'b10011;
   localparam logic [4:0] OP_BLT = 5'b10100;
   localparam logic [4:0] OP_BGT = 5'b10101;
   localparam logic [4:0] OP_BNE = 5'b10110;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } fetch_state_t;

   function automatic logic is_branch(input logic [4:0] opcode);
      return (opcode == OP_BEQ) || (opcode == OP_BLT) ||
             (opcode == OP_BGT) || (opcode == OP_BNE);
   endfunction

endpackage

// File: rtl/branch_tgt_fifo.sv
// In-order queue of pending branch targets.
// The head entry is readable combinationally, and clear takes priority over push and pop.
module branch_tgt_fifo #(
   parameter int PC_W  = 16,
   parameter int DEPTH = 4,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            push,
   input  logic            pop,
   input  logic            clear,
   input  logic [PC_W-1:0] din,
   output logic [PC_W-1:0] dout,
   output logic [CW-1:0]   count
);

   logic [PC_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   count_q, count_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // NOTE: storage is deliberately not reset; validity is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (push && !clear) mem_q[wr_ptr_q] <= din;
   end

   assign dout  = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC owner with predict-not-taken branching.
// A taken resolution redirects the PC to the queued target and holds flush_out for FLUSH_CYCLES.
module pc_fetch_ctrl
   import cpu_pkg::*;
#(
   parameter int              PC_W         = 16,
   parameter int              DEPTH        = 4,
   parameter int              FLUSH_CYCLES = 2,
   parameter logic [PC_W-1:0] RESET_PC     = '0
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            stall_in,
   input  logic            imem_ready,
   input  logic            dec_valid,
   input  logic [4:0]      dec_opcode,
   input  logic [PC_W-1:0] dec_target,
   input  logic            br_resolve_valid,
   input  logic            pc_branch_sel_in,
   output logic [PC_W-1:0] pc_out,
   output logic            pc_valid,
   output logic            flush_out,
   output logic            queue_full,
   output logic            branch_err
);

   localparam int CW   = $clog2(DEPTH) + 1;
   localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

   fetch_state_t    state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic            pc_valid_q, pc_valid_d;
   logic            flush_q, flush_d;
   logic            err_q, err_d;
   logic [FC_W-1:0] cnt_q, cnt_d;

   logic            push_req, resolve, pop, taken, fifo_push, empty;
   logic [PC_W-1:0] head_tgt;
   logic [CW-1:0]   count;

   branch_tgt_fifo #(.PC_W(PC_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .pop   (pop),
      .clear (taken),
      .din   (dec_target),
      .dout  (head_tgt),
      .count (count)
   );

   assign empty      = (count == '0);
   assign queue_full = (count == CW'(DEPTH));

   // A full queue still accepts a push when a pop frees a slot in the same cycle.
   always_comb begin
      push_req  = dec_valid && is_branch(dec_opcode) && (state_q == RUN);
      resolve   = br_resolve_valid && (state_q == RUN);
      pop       = resolve && !empty;
      taken     = pop && pc_branch_sel_in;
      fifo_push = push_req && !taken && (!queue_full || pop);
   end

   // NOTE: every next-state signal gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pc_valid_d = pc_valid_q;
      flush_d    = flush_q;
      err_d      = err_q;
      cnt_d      = cnt_q;
      case (state_q)
         RUN: begin
            pc_valid_d = 1'b1;
            flush_d    = 1'b0;
            if (taken) begin
               pc_d       = head_tgt;
               pc_valid_d = 1'b0;
               flush_d    = 1'b1;
               cnt_d      = FC_W'(FLUSH_CYCLES - 1);
               state_d    = FLUSH;
            end else if (pc_valid_q && imem_ready && !stall_in && !queue_full) begin
               pc_d = pc_q + 1'b1;
            end
            if ((push_req && queue_full && !pop) || (resolve && empty)) err_d = 1'b1;
         end
         FLUSH: begin
            pc_valid_d = 1'b0;
            flush_d    = 1'b1;
            if (cnt_q == '0) begin
               state_d    = RUN;
               flush_d    = 1'b0;
               pc_valid_d = 1'b1;
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end
         default: state_d = RUN;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= RUN;
         pc_q       <= RESET_PC;
         pc_valid_q <= 1'b0;
         flush_q    <= 1'b0;
         err_q      <= 1'b0;
         cnt_q      <= '0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pc_valid_q <= pc_valid_d;
         flush_q    <= flush_d;
         err_q      <= err_d;
         cnt_q      <= cnt_d;
      end
   end

   assign pc_out     = pc_q;
   assign pc_valid   = pc_valid_q;
   assign flush_out  = flush_q;
   assign branch_err = err_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl.
// Expected values are hand-derived and sampled 1 ns after each rising edge.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall_in;
   logic        imem_ready;
   logic        dec_valid;
   logic [4:0]  dec_opcode;
   logic [15:0] dec_target;
   logic        br_resolve_valid;
   logic        pc_branch_sel_in;
   logic [15:0] pc_out;
   logic        pc_valid;
   logic        flush_out;
   logic        queue_full;
   logic        branch_err;

   int n_vec = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   pc_fetch_ctrl #(.PC_W(16), .DEPTH(4), .FLUSH_CYCLES(2), .RESET_PC(16'h0000)) dut (
      .clk              (clk),
      .rst              (rst),
      .stall_in         (stall_in),
      .imem_ready       (imem_ready),
      .dec_valid        (dec_valid),
      .dec_opcode       (dec_opcode),
      .dec_target       (dec_target),
      .br_resolve_valid (br_resolve_valid),
      .pc_branch_sel_in (pc_branch_sel_in),
      .pc_out           (pc_out),
      .pc_valid         (pc_valid),
      .flush_out        (flush_out),
      .queue_full       (queue_full),
      .branch_err       (branch_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_all(input string tag, input logic [15:0] pc, input logic v,
                          input logic fl, input logic full, input logic err);
      check({tag, ".pc"},    32'(pc_out),     32'(pc));
      check({tag, ".valid"}, 32'(pc_valid),   32'(v));
      check({tag, ".flush"}, 32'(flush_out),  32'(fl));
      check({tag, ".full"},  32'(queue_full), 32'(full));
      check({tag, ".err"},   32'(branch_err), 32'(err));
   endtask

   task automatic push(input logic [4:0] op, input logic [15:0] tgt);
      dec_valid  = 1'b1;
      dec_opcode = op;
      dec_target = tgt;
   endtask

   task automatic idle_dec();
      dec_valid  = 1'b0;
      dec_opcode = 5'b00000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      idle_dec();
      br_resolve_valid = 1'b0;
      pc_branch_sel_in = 1'b0;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; stall_in = 1'b0; imem_ready = 1'b0;
      dec_valid = 1'b0; dec_opcode = 5'b0; dec_target = 16'h0;
      br_resolve_valid = 1'b0; pc_branch_sel_in = 1'b0;
      tick();
      tick();
      chk_all("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

      // sequential fetch: pc_valid first, then one increment per cycle
      rst = 1'b0; imem_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_all($sformatf("seq%0d", i), 16'(i), 1'b1, 1'b0, 1'b0, 1'b0);
      end

      // not-taken BEQ
      push(5'b10011, 16'h0040);
      tick();
      check("beq_push.pc", 32'(pc_out), 32'h5);
      idle_dec(); br_resolve_valid = 1'b1; pc_branch_sel_in = 1'b0;
      tick();
      chk_all("beq_nt", 16'h0006, 1'b1, 1'b0, 1'b0, 1'b0);
      br_resolve_valid = 1'b0;

      // taken BNE with a 2-cycle flush
      push(5'b10110, 16'h1234);
      tick();
      check("bne_push.pc", 32'(pc_out), 32'h7);
      idle_dec(); br_resolve_valid = 1'b1; pc_branch_sel_in = 1'b1;
      tick();
      chk_all("bne_t0", 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
      br_resolve_valid = 1'b0; pc_branch_sel_in = 1'b0;
      tick();
      chk_all("bne_t1", 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0);
      tick();
      chk_all("bne_t2", 16'h1234, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("bne_t3", 16'h1235, 1'b1, 1'b0, 1'b0, 1'b0);

      // fill the queue, overflow, then drain one
      for (int i = 0; i < 4; i++) begin
         push(5'b10101, 16'h0100 + 16'(i));
         tick();
      end
      chk_all("full", 16'h1239, 1'b1, 1'b0, 1'b1, 1'b0);
      push(5'b10100, 16'h0200);
      tick();
      chk_all("ovf", 16'h1239, 1'b1, 1'b0, 1'b1, 1'b1);
      idle_dec();
      tick();
      chk_all("frozen", 16'h1239, 1'b1, 1'b0, 1'b1, 1'b1);
      br_resolve_valid = 1'b1; pc_branch_sel_in = 1'b0;
      tick();
      chk_all("drain", 16'h1239, 1'b1, 1'b0, 1'b0, 1'b1);
      br_resolve_valid = 1'b0;
      tick();
      chk_all("resume", 16'h123A, 1'b1, 1'b0, 1'b0, 1'b1);

      // reset clears the sticky error and the queue
      do_reset();
      #1;
      chk_all("rst2", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
      tick();
      check("rst2_run.valid", 32'(pc_valid), 32'h1);

      // taken BGT overrides a same-cycle BLT push
      push(5'b10101, 16'h0010);
      tick();
      check("bgt_push.pc", 32'(pc_out), 32'h1);
      push(5'b10100, 16'h0999);
      br_resolve_valid = 1'b1; pc_branch_sel_in = 1'b1;
      tick();
      chk_all("ovr_t0", 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0);
      idle_dec(); br_resolve_valid = 1'b0; pc_branch_sel_in = 1'b0;
      tick();
      tick();
      chk_all("ovr_t2", 16'h0010, 1'b1, 1'b0, 1'b0, 1'b0);
      // queue must be empty now, so this resolve is an error
      br_resolve_valid = 1'b1;
      tick();
      chk_all("empty_res", 16'h0011, 1'b1, 1'b0, 1'b0, 1'b1);
      br_resolve_valid = 1'b0;

      // PC wrap at all-ones, reached through a redirect
      do_reset();
      tick();
      push(5'b10011, 16'hFFFF);
      tick();
      idle_dec(); br_resolve_valid = 1'b1; pc_branch_sel_in = 1'b1;
      tick();
      br_resolve_valid = 1'b0; pc_branch_sel_in = 1'b0;
      tick();
      tick();
      chk_all("wrap0", 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b0);
      tick();
      chk_all("wrap1", 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0);

      // stall and imem_ready each hold the PC
      stall_in = 1'b1;
      tick();
      check("stall.pc", 32'(pc_out), 32'h0);
      stall_in = 1'b0; imem_ready = 1'b0;
      tick();
      check("noready.pc", 32'(pc_out), 32'h0);
      imem_ready = 1'b1;
      tick();
      check("ready.pc", 32'(pc_out), 32'h1);

      // reset mid-FLUSH
      push(5'b10110, 16'h0ABC);
      tick();
      idle_dec(); br_resolve_valid = 1'b1; pc_branch_sel_in = 1'b1;
      tick();
      chk_all("midfl", 16'h0ABC, 1'b0, 1'b1, 1'b0, 1'b0);
      do_reset();
      #1;
      chk_all("midfl_rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
